pc_seq_unit: RTL

- Parametrised program-counter sequencer; next generation of the single-target PC.
- Computes the next fetch address on-chip: sequential increment, absolute jump, signed relative branch, and call/return through an internal return-address stack (RAS).
- Sits between the decoder/branch logic and instruction memory; prog_ctr drives the instruction ROM address directly.

---
 rtl/pc_seq_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pc_seq_unit.sv
// rtl/pc_seq_unit.sv - program-counter sequencer with return-address stack
//
// Purpose: computes the next instruction fetch address each cycle. Supported
// actions are increment, absolute jump, signed relative branch, and
// call/return through a circular return-address stack (RAS).
//
// Optional feature macro: PC_BOUNDS_CHECK_EN
//   When defined, any next PC above PROG_LIMIT is refused, pc_fault is set,
//   and the PC freezes until reset.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall               hold all state this cycle
//   jump_abs, target    absolute jump to target
//   branch, offset      relative branch by sign-extended offset
//   call, ret           push prog_ctr+1 and jump / pop into prog_ctr
//   prog_ctr            registered fetch address
//   ras_depth           number of valid RAS entries
//   ras_ovf, ras_unf    sticky RAS overflow / underflow flags
//   pc_fault            sticky bounds fault (0 when feature compiled out)
module pc_seq_unit #(
    parameter int             D          = 12,
    parameter int             OFS_W      = 8,
    parameter int             RAS_DEPTH  = 4,
    parameter logic [D-1:0]   RESET_VEC  = '0,
    parameter logic [D-1:0]   PROG_LIMIT = {D{1'b1}}
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           jump_abs,
    input  logic                           branch,
    input  logic                           call,
    input  logic                           ret,
    input  logic [D-1:0]                   target,
    input  logic [OFS_W-1:0]               offset,
    output logic [D-1:0]                   prog_ctr,
    output logic [$clog2(RAS_DEPTH):0]     ras_depth,
    output logic                           ras_ovf,
    output logic                           ras_unf,
    output logic                           pc_fault
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int DW = AW + 1;

    logic [D-1:0]  pc_q, pc_d;
    logic [AW-1:0] sp_q, sp_d;            // next write slot; top entry is sp_q-1
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [D-1:0]  ras_mem_q [RAS_DEPTH];
    logic [D-1:0]  ras_mem_d [RAS_DEPTH];

    logic [D-1:0]  pc_inc;
    logic [D-1:0]  ofs_ext;
    logic [D-1:0]  pc_next;
    logic [AW-1:0] sp_top;
    logic          ras_full, ras_empty;
    logic          do_push, do_pop, do_unf;
    logic          commit;

`ifdef PC_BOUNDS_CHECK_EN
    logic          fault_q, fault_d;
    logic          over_limit;
`endif

    always_comb begin
        pc_inc    = pc_q + 1'b1;
        ofs_ext   = D'($signed(offset));
        sp_top    = AW'(sp_q - 1'b1);
        ras_full  = (depth_q == DW'(RAS_DEPTH));
        ras_empty = (depth_q == '0);

        // Select the single winning action; lower-priority requests are dropped.
        pc_next = pc_inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_unf  = 1'b0;
        if (ret) begin
            if (!ras_empty) begin
                pc_next = ras_mem_q[sp_top];
                do_pop  = 1'b1;
            end else begin
                do_unf  = 1'b1;
            end
        end else if (call) begin
            pc_next = target;
            do_push = 1'b1;
        end else if (jump_abs) begin
            pc_next = target;
        end else if (branch) begin
            pc_next = pc_q + ofs_ext;
        end

`ifdef PC_BOUNDS_CHECK_EN
        over_limit = (pc_next > PROG_LIMIT);
        commit     = !stall && !fault_q && !over_limit;
        fault_d    = fault_q | (!stall && over_limit);
`else
        commit     = !stall;
`endif

        pc_d      = pc_q;
        sp_d      = sp_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ras_mem_d = ras_mem_q;
        if (commit) begin
            pc_d = pc_next;
            if (do_push) begin
                // When full the write slot holds the oldest entry, so it is overwritten.
                ras_mem_d[sp_q] = pc_inc;
                sp_d            = AW'(sp_q + 1'b1);
                if (ras_full) ovf_d   = 1'b1;
                else          depth_d = depth_q + 1'b1;
            end
            if (do_pop) begin
                sp_d    = sp_top;
                depth_d = depth_q - 1'b1;
            end
            if (do_unf) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries beyond ras_depth are never read, so the storage needs no reset.
    always_ff @(posedge clk) begin
        ras_mem_q <= ras_mem_d;
    end

`ifdef PC_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end
    assign pc_fault = fault_q;
`else
    logic unused_prog_limit;
    assign unused_prog_limit = ^PROG_LIMIT;
    assign pc_fault = 1'b0;
`endif

    assign prog_ctr  = pc_q;
    assign ras_depth = depth_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule
